// File: rtl/fifo_pkg.sv
// fifo_pkg: mode constants, depth helper and parameter sanity check shared by
// the fifo_lvl family.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_CHECK_PARAMS(DEPTH_V, AF_V, AE_V) \
  if (((AF_V) < 1) || ((AF_V) > (DEPTH_V)) || ((AE_V) < 0) || ((AE_V) > ((DEPTH_V) - 1))) begin : g_bad_params \
    $error("fifo_lvl: AF_TH or AE_TH outside legal range"); \
  end

package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int lgflen);
    return 1 << lgflen;
  endfunction

endpackage

`endif

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage for fifo_lvl. No reset so that the
// array maps onto block RAM; the read port only updates when rd_en is high,
// which lets the FIFO use rd_data directly as its held output word.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int BW     = 32,
  parameter int LGFLEN = 10
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [LGFLEN-1:0] wr_addr,
  input  logic [BW-1:0]     wr_data,
  input  logic              rd_en,
  input  logic [LGFLEN-1:0] rd_addr,
  output logic [BW-1:0]     rd_data
);

  localparam int DEPTH = fifo_depth(LGFLEN);

  logic [BW-1:0] mem [0:DEPTH-1];

  // write port: store the incoming word at the write address
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // read port: fetch a word only when asked, otherwise keep the last one
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: power-of-two synchronous FIFO with optional show-ahead output,
// fill level with almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
module fifo_lvl
  import fifo_pkg::*;
#(
  parameter int BW        = 32,
  parameter int LGFLEN    = 10,
  parameter int SHOWAHEAD = 0,
  parameter int AF_TH     = (1 << LGFLEN) - 4,
  parameter int AE_TH     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [BW-1:0]     data,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [BW-1:0]     q,
  output logic              empty,
  output logic              full,
  output logic [LGFLEN:0]   usedw,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = fifo_depth(LGFLEN);
  localparam logic [LGFLEN:0] DEPTH_W = (LGFLEN+1)'(DEPTH);
  localparam logic [LGFLEN:0] AF_W    = (LGFLEN+1)'(AF_TH);
  localparam logic [LGFLEN:0] AE_W    = (LGFLEN+1)'(AE_TH);
  localparam bit              FWFT    = (SHOWAHEAD != FIFO_MODE_REG);

  `FIFO_CHECK_PARAMS(DEPTH, AF_TH, AE_TH)

  logic [LGFLEN:0] wr_ptr;
  logic [LGFLEN:0] rd_ptr;
  logic [LGFLEN:0] usedw_r;
  logic [LGFLEN:0] ram_words;
  logic            head_valid;
  logic            head_next;
  logic            q_loaded;
  logic            overflow_r;
  logic            underflow_r;
  logic            wr_acc;
  logic            rd_acc;
  logic            ram_rd;
  logic [BW-1:0]   ram_q;

  fifo_ram #(
    .BW     (BW),
    .LGFLEN (LGFLEN)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[LGFLEN-1:0]),
    .wr_data (data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr[LGFLEN-1:0]),
    .rd_data (ram_q)
  );

  // status flags come only from registered state, never from this cycle's requests
  always_comb begin
    full         = (usedw_r == DEPTH_W);
    empty        = FWFT ? !head_valid : (usedw_r == '0);
    almost_full  = (usedw_r >= AF_W);
    almost_empty = (usedw_r <= AE_W);
  end

  // accept decisions and RAM read scheduling; in show-ahead mode the RAM
  // read port refills the head whenever it is vacant or being consumed
  always_comb begin
    wr_acc    = wrreq && !full && !clear;
    rd_acc    = rdreq && !empty && !clear;
    ram_words = wr_ptr - rd_ptr;
    ram_rd    = rd_acc;
    head_next = 1'b0;
    if (FWFT) begin
      ram_rd    = (!head_valid || rd_acc) && (ram_words != '0) && !clear;
      head_next = head_valid;
      if (clear) begin
        head_next = 1'b0;
      end else if (ram_rd) begin
        head_next = 1'b1;
      end else if (rd_acc) begin
        head_next = 1'b0;
      end
    end
  end

  // pointers and the explicit occupancy counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        usedw_r <= usedw_r + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        usedw_r <= usedw_r - 1'b1;
      end
    end
  end

  // head-valid bit for show-ahead mode, plus a marker that q has been loaded
  // since reset so q reads as zero until the RAM port has produced a word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_valid <= 1'b0;
      q_loaded   <= 1'b0;
    end else begin
      head_valid <= head_next;
      if (ram_rd) begin
        q_loaded <= 1'b1;
      end
    end
  end

  // sticky error flags; a flush wins over a simultaneous bad request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clear) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wrreq && full) begin
        overflow_r <= 1'b1;
      end
      if (rdreq && empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign q         = q_loaded ? ram_q : '0;
  assign usedw     = usedw_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed scenarios on a 4-deep pair (registered and show-ahead)
// plus randomized traffic on an 8-deep pair checked against queue models.
module tb_fifo_lvl;
  import fifo_pkg::*;

  localparam int A_AF    = 3;
  localparam int A_AE    = 1;
  localparam int B_DEPTH = 8;
  localparam int B_AF    = 4;
  localparam int B_AE    = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b1;

  logic       a_clear, a_wrreq, a_rdreq;
  logic [7:0] a_data;
  logic       b_clear, b_wrreq, b_rdreq;
  logic [7:0] b_data;

  logic [7:0] a0_q, a1_q, b0_q, b1_q;
  logic [2:0] a0_usedw, a1_usedw;
  logic [3:0] b0_usedw, b1_usedw;
  logic a0_empty, a0_full, a0_af, a0_ae, a0_ovf, a0_udf;
  logic a1_empty, a1_full, a1_af, a1_ae, a1_ovf, a1_udf;
  logic b0_empty, b0_full, b0_af, b0_ae, b0_ovf, b0_udf;
  logic b1_empty, b1_full, b1_af, b1_ae, b1_ovf, b1_udf;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  fifo_lvl #(.BW(8), .LGFLEN(2), .SHOWAHEAD(FIFO_MODE_REG), .AF_TH(A_AF), .AE_TH(A_AE)) u_a0 (
    .clock(clock), .reset_n(reset_n), .clear(a_clear), .data(a_data), .wrreq(a_wrreq), .rdreq(a_rdreq),
    .q(a0_q), .empty(a0_empty), .full(a0_full), .usedw(a0_usedw), .almost_full(a0_af),
    .almost_empty(a0_ae), .overflow(a0_ovf), .underflow(a0_udf));

  fifo_lvl #(.BW(8), .LGFLEN(2), .SHOWAHEAD(FIFO_MODE_FWFT), .AF_TH(A_AF), .AE_TH(A_AE)) u_a1 (
    .clock(clock), .reset_n(reset_n), .clear(a_clear), .data(a_data), .wrreq(a_wrreq), .rdreq(a_rdreq),
    .q(a1_q), .empty(a1_empty), .full(a1_full), .usedw(a1_usedw), .almost_full(a1_af),
    .almost_empty(a1_ae), .overflow(a1_ovf), .underflow(a1_udf));

  fifo_lvl #(.BW(8), .LGFLEN(3), .SHOWAHEAD(FIFO_MODE_REG), .AF_TH(B_AF), .AE_TH(B_AE)) u_b0 (
    .clock(clock), .reset_n(reset_n), .clear(b_clear), .data(b_data), .wrreq(b_wrreq), .rdreq(b_rdreq),
    .q(b0_q), .empty(b0_empty), .full(b0_full), .usedw(b0_usedw), .almost_full(b0_af),
    .almost_empty(b0_ae), .overflow(b0_ovf), .underflow(b0_udf));

  fifo_lvl #(.BW(8), .LGFLEN(3), .SHOWAHEAD(FIFO_MODE_FWFT), .AF_TH(B_AF), .AE_TH(B_AE)) u_b1 (
    .clock(clock), .reset_n(reset_n), .clear(b_clear), .data(b_data), .wrreq(b_wrreq), .rdreq(b_rdreq),
    .q(b1_q), .empty(b1_empty), .full(b1_full), .usedw(b1_usedw), .almost_full(b1_af),
    .almost_empty(b1_ae), .overflow(b1_ovf), .underflow(b1_udf));

  // drive one cycle of requests on the small pair, return just after the edge
  task automatic applyStimulus(input logic clr, input logic wr, input logic rd, input logic [7:0] d);
    @(negedge clock);
    a_clear = clr;
    a_wrreq = wr;
    a_rdreq = rd;
    a_data  = d;
    @(posedge clock);
    #1;
  endtask

  // reset everything with all requests idle
  task automatic resetAll();
    @(negedge clock);
    reset_n = 1'b0;
    a_clear = 1'b0; a_wrreq = 1'b0; a_rdreq = 1'b0; a_data = 8'h00;
    b_clear = 1'b0; b_wrreq = 1'b0; b_rdreq = 1'b0; b_data = 8'h00;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    a_clear = 1'b0; a_wrreq = 1'b0; a_rdreq = 1'b0; a_data = 8'h00;
    b_clear = 1'b0; b_wrreq = 1'b0; b_rdreq = 1'b0; b_data = 8'h00;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    compared += 4;
    if ({a0_q, a0_usedw, a0_empty, a0_full, a0_af, a0_ae, a0_ovf, a0_udf} !== {8'h00, 3'd0, 6'b100100}) begin
      mismatched++;
      $display("[TB] FAIL reset_a0: got %h expected %h", {a0_q, a0_usedw, a0_empty, a0_full, a0_af, a0_ae, a0_ovf, a0_udf}, {8'h00, 3'd0, 6'b100100});
    end
    if ({a1_q, a1_usedw, a1_empty, a1_full, a1_af, a1_ae, a1_ovf, a1_udf} !== {8'h00, 3'd0, 6'b100100}) begin
      mismatched++;
      $display("[TB] FAIL reset_a1: got %h expected %h", {a1_q, a1_usedw, a1_empty, a1_full, a1_af, a1_ae, a1_ovf, a1_udf}, {8'h00, 3'd0, 6'b100100});
    end
    if ({b0_q, b0_usedw, b0_empty, b0_full, b0_af, b0_ae, b0_ovf, b0_udf} !== {8'h00, 4'd0, 6'b100100}) begin
      mismatched++;
      $display("[TB] FAIL reset_b0: got %h expected %h", {b0_q, b0_usedw, b0_empty, b0_full, b0_af, b0_ae, b0_ovf, b0_udf}, {8'h00, 4'd0, 6'b100100});
    end
    if ({b1_q, b1_usedw, b1_empty, b1_full, b1_af, b1_ae, b1_ovf, b1_udf} !== {8'h00, 4'd0, 6'b100100}) begin
      mismatched++;
      $display("[TB] FAIL reset_b1: got %h expected %h", {b1_q, b1_usedw, b1_empty, b1_full, b1_af, b1_ae, b1_ovf, b1_udf}, {8'h00, 4'd0, 6'b100100});
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_fill_overflow();
    logic [7:0] w [4];
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    resetAll();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, w[k]);
      compared++;
      if ({a0_usedw, a0_full} !== {3'(k + 1), 1'(k == 3)}) begin
        mismatched++;
        $display("[TB] FAIL fill_level k=%0d: got %h expected %h", k, {a0_usedw, a0_full}, {3'(k + 1), 1'(k == 3)});
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h55);
    compared++;
    if ({a0_usedw, a0_full, a0_ovf} !== {3'd4, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL overflow_set: got %h expected %h", {a0_usedw, a0_full, a0_ovf}, {3'd4, 1'b1, 1'b1});
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      compared++;
      if (a0_q !== w[k]) begin
        mismatched++;
        $display("[TB] FAIL read_order k=%0d: got %h expected %h", k, a0_q, w[k]);
      end
    end
    compared++;
    if ({a0_empty, a0_usedw} !== {1'b1, 3'd0}) begin
      mismatched++;
      $display("[TB] FAIL drained: got %h expected %h", {a0_empty, a0_usedw}, {1'b1, 3'd0});
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    compared++;
    if ({a0_udf, a0_q} !== {1'b1, 8'h44}) begin
      mismatched++;
      $display("[TB] FAIL underflow_set: got %h expected %h", {a0_udf, a0_q}, {1'b1, 8'h44});
    end
  endtask

  task automatic test_thresholds();
    resetAll();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(k));
      compared++;
      if ({a0_af, a0_ae} !== {1'(k >= A_AF), 1'(k <= A_AE)}) begin
        mismatched++;
        $display("[TB] FAIL thresh_fill level=%0d: got %b expected %b", k, {a0_af, a0_ae}, {1'(k >= A_AF), 1'(k <= A_AE)});
      end
    end
    for (int k = 3; k >= 0; k--) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      compared++;
      if ({a0_af, a0_ae} !== {1'(k >= A_AF), 1'(k <= A_AE)}) begin
        mismatched++;
        $display("[TB] FAIL thresh_drain level=%0d: got %b expected %b", k, {a0_af, a0_ae}, {1'(k >= A_AF), 1'(k <= A_AE)});
      end
    end
  endtask

  task automatic test_simultaneous();
    resetAll();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h03);
    compared++;
    if ({a0_usedw, a0_q} !== {3'd2, 8'h01}) begin
      mismatched++;
      $display("[TB] FAIL simul_mid: got %h expected %h", {a0_usedw, a0_q}, {3'd2, 8'h01});
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h04);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h06);
    compared++;
    if ({a0_usedw, a0_q, a0_ovf, a0_full} !== {3'd3, 8'h02, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL simul_full: got %h expected %h", {a0_usedw, a0_q, a0_ovf, a0_full}, {3'd3, 8'h02, 1'b1, 1'b0});
    end
    for (int k = 3; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      compared++;
      if (a0_q !== 8'(k)) begin
        mismatched++;
        $display("[TB] FAIL simul_tail k=%0d: got %h expected %h", k, a0_q, 8'(k));
      end
    end
  endtask

  task automatic test_clear();
    resetAll();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h30 + k));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h35);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    compared++;
    if ({a0_usedw, a0_q, a0_ovf, a0_udf} !== {3'd3, 8'h31, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL clear_setup: got %h expected %h", {a0_usedw, a0_q, a0_ovf, a0_udf}, {3'd3, 8'h31, 1'b1, 1'b1});
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
    compared++;
    if ({a0_q, a0_usedw, a0_empty, a0_full, a0_af, a0_ae, a0_ovf, a0_udf} !== {8'h31, 3'd0, 6'b100100}) begin
      mismatched++;
      $display("[TB] FAIL clear_state: got %h expected %h", {a0_q, a0_usedw, a0_empty, a0_full, a0_af, a0_ae, a0_ovf, a0_udf}, {8'h31, 3'd0, 6'b100100});
    end
  endtask

  task automatic test_fwft_first_word();
    resetAll();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
    compared++;
    if ({a1_usedw, a1_empty} !== {3'd1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL fwft_after_write: got %h expected %h", {a1_usedw, a1_empty}, {3'd1, 1'b1});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    compared++;
    if ({a1_empty, a1_q} !== {1'b0, 8'hA5}) begin
      mismatched++;
      $display("[TB] FAIL fwft_head: got %h expected %h", {a1_empty, a1_q}, {1'b0, 8'hA5});
    end
  endtask

  task automatic test_fwft_refill();
    resetAll();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h20);
    compared++;
    if ({a1_empty, a1_usedw, a1_q} !== {1'b1, 3'd1, 8'h10}) begin
      mismatched++;
      $display("[TB] FAIL fwft_bubble: got %h expected %h", {a1_empty, a1_usedw, a1_q}, {1'b1, 3'd1, 8'h10});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    compared++;
    if ({a1_empty, a1_q} !== {1'b0, 8'h20}) begin
      mismatched++;
      $display("[TB] FAIL fwft_refill: got %h expected %h", {a1_empty, a1_q}, {1'b0, 8'h20});
    end
  endtask

  task automatic test_back_to_back();
    resetAll();
    for (int k = 0; k <= 100; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(k));
      compared++;
      if (k == 0) begin
        if ({a1_empty, a1_q} !== {1'b1, 8'h00}) begin
          mismatched++;
          $display("[TB] FAIL stream k=%0d: got %h expected %h", k, {a1_empty, a1_q}, {1'b1, 8'h00});
        end
      end else if ({a1_empty, a1_q} !== {1'b0, 8'(k - 1)}) begin
        mismatched++;
        $display("[TB] FAIL stream k=%0d: got %h expected %h", k, {a1_empty, a1_q}, {1'b0, 8'(k - 1)});
      end
    end
    compared++;
    if (a1_usedw !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL stream_level: got %0d expected 2", a1_usedw);
    end
  endtask

  task automatic test_random();
    logic [7:0]  m0q [$];
    logic [7:0]  m1q [$];
    logic [7:0]  m0_q, m1_q, d;
    logic        m0_ovf, m0_udf, m1_ovf, m1_udf, m1_valid;
    logic        m0_full, m0_empty, m1_full, m1_empty;
    logic        clr, wr, rd, consume, load;
    int          wp, rp, ram_words;
    logic [17:0] exp0, exp1;
    resetAll();
    m0_q = 8'h00; m0_ovf = 1'b0; m0_udf = 1'b0;
    m1_q = 8'h00; m1_ovf = 1'b0; m1_udf = 1'b0; m1_valid = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      case ((i / 250) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 55; rp = 55; end
      endcase
      clr = ($urandom_range(0, 299) == 0);
      wr  = ($urandom_range(0, 99) < wp);
      rd  = ($urandom_range(0, 99) < rp);
      d   = 8'($urandom);
      @(negedge clock);
      reset_n = 1'b1;
      b_clear = clr; b_wrreq = wr; b_rdreq = rd; b_data = d;

      m0_full  = (m0q.size() == B_DEPTH);
      m0_empty = (m0q.size() == 0);
      if (clr) begin
        m0q.delete(); m0_ovf = 1'b0; m0_udf = 1'b0;
      end else begin
        if (wr && m0_full) m0_ovf = 1'b1;
        if (rd && m0_empty) m0_udf = 1'b1;
        if (rd && !m0_empty) m0_q = m0q.pop_front();
        if (wr && !m0_full) m0q.push_back(d);
      end

      m1_full  = (m1q.size() == B_DEPTH);
      m1_empty = !m1_valid;
      if (clr) begin
        m1q.delete(); m1_valid = 1'b0; m1_ovf = 1'b0; m1_udf = 1'b0;
      end else begin
        if (wr && m1_full) m1_ovf = 1'b1;
        if (rd && m1_empty) m1_udf = 1'b1;
        consume = rd && m1_valid;
        if (consume) void'(m1q.pop_front());
        ram_words = m1q.size() - ((m1_valid && !consume) ? 1 : 0);
        load = (!m1_valid || consume) && (ram_words > 0);
        if (load) begin
          m1_q = m1q[0];
          m1_valid = 1'b1;
        end else if (consume) begin
          m1_valid = 1'b0;
        end
        if (wr && !m1_full) m1q.push_back(d);
      end

      exp0 = {m0_q, 4'(m0q.size()), 1'(m0q.size() == 0), 1'(m0q.size() == B_DEPTH),
              1'(m0q.size() >= B_AF), 1'(m0q.size() <= B_AE), m0_ovf, m0_udf};
      exp1 = {m1_q, 4'(m1q.size()), !m1_valid, 1'(m1q.size() == B_DEPTH),
              1'(m1q.size() >= B_AF), 1'(m1q.size() <= B_AE), m1_ovf, m1_udf};
      @(posedge clock);
      #1;
      compared += 2;
      if ({b0_q, b0_usedw, b0_empty, b0_full, b0_af, b0_ae, b0_ovf, b0_udf} !== exp0) begin
        mismatched++;
        $display("[TB] FAIL rand_mode0 cycle=%0d: got %h expected %h", i, {b0_q, b0_usedw, b0_empty, b0_full, b0_af, b0_ae, b0_ovf, b0_udf}, exp0);
      end
      if ({b1_q, b1_usedw, b1_empty, b1_full, b1_af, b1_ae, b1_ovf, b1_udf} !== exp1) begin
        mismatched++;
        $display("[TB] FAIL rand_mode1 cycle=%0d: got %h expected %h", i, {b1_q, b1_usedw, b1_empty, b1_full, b1_af, b1_ae, b1_ovf, b1_udf}, exp1);
      end

      if (i == 2500) begin
        #1;
        reset_n = 1'b0;
        #1;
        compared += 2;
        if ({b0_q, b0_usedw, b0_empty, b0_full, b0_af, b0_ae, b0_ovf, b0_udf} !== {8'h00, 4'd0, 6'b100100}) begin
          mismatched++;
          $display("[TB] FAIL rand_reset_mode0: got %h expected %h", {b0_q, b0_usedw, b0_empty, b0_full, b0_af, b0_ae, b0_ovf, b0_udf}, {8'h00, 4'd0, 6'b100100});
        end
        if ({b1_q, b1_usedw, b1_empty, b1_full, b1_af, b1_ae, b1_ovf, b1_udf} !== {8'h00, 4'd0, 6'b100100}) begin
          mismatched++;
          $display("[TB] FAIL rand_reset_mode1: got %h expected %h", {b1_q, b1_usedw, b1_empty, b1_full, b1_af, b1_ae, b1_ovf, b1_udf}, {8'h00, 4'd0, 6'b100100});
        end
        m0q.delete(); m0_q = 8'h00; m0_ovf = 1'b0; m0_udf = 1'b0;
        m1q.delete(); m1_q = 8'h00; m1_ovf = 1'b0; m1_udf = 1'b0; m1_valid = 1'b0;
      end
    end
  endtask

  // run every scenario in sequence and report once at the end
  initial begin
    $display("[TB] starting fifo_lvl checks");
    test_reset();
    test_fill_overflow();
    test_thresholds();
    test_simultaneous();
    test_clear();
    test_fwft_first_word();
    test_fwft_refill();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
